// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a 4-phase req/ack CDC handshake.
// Holds one accepted word on o_data and drives a registered o_req until the synchronized ack completes.
module cdc_handshake_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_req,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ack,
    output logic             o_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   done_q, done_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;
    logic                   accept;

    // i_ack enters only through this chain; everything else sees ack_s.
    assign ack_s   = ack_sync_q[SYNC_STAGES-1];
    assign o_ready = (state_q == ST_IDLE) && !ack_s;
    assign accept  = i_valid && o_ready;

    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], i_ack};
        state_d    = state_q;
        req_d      = req_q;
        data_d     = data_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = i_data;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Transfer is complete only once the receiver has dropped ack.
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign o_req  = req_q;
    assign o_data = data_q;
    assign o_done = done_q;

endmodule
